// File: rtl/shift_pkg.sv
// Shared constants for the shift_pipe shifter/rotator: widths, depth and op codes.
package shift_pkg;

  localparam int WIDTH  = 16;
  localparam int CNT_W  = 4;
  localparam int STAGES = 4;

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One combinational shift/rotate step by a fixed distance DIST, applied when en is set.
module shift_stage
  import shift_pkg::*;
#(
  parameter int DIST = 1
) (
  input  logic [WIDTH-1:0] x,
  input  logic             en,
  input  logic [1:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = x;
    if (en) begin
      case (op)
        OP_ROL:  y = {x[WIDTH-1-DIST:0], x[WIDTH-1:WIDTH-DIST]};
        OP_SLL:  y = {x[WIDTH-1-DIST:0], {DIST{1'b0}}};
        OP_ROR:  y = {x[DIST-1:0], x[WIDTH-1:DIST]};
        default: y = {{DIST{1'b0}}, x[WIDTH-1:DIST]};
      endcase
    end
  end

endmodule

// File: rtl/shift_pipe.sv
// Four-stage pipelined 16-bit shifter/rotator; stage g applies distance 2^g per count bit g.
module shift_pipe
  import shift_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [CNT_W-1:0] in_cnt,
  input  logic [1:0]       in_op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             busy
);

  // Handshake: a transfer happens on any edge where valid & ready are both high;
  // ready is combinational from the stage valid bits back from out_ready.
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [WIDTH-1:0]  data    [STAGES];
  logic [CNT_W-1:0]  cnt     [STAGES];
  logic [1:0]        op      [STAGES];

  logic [WIDTH-1:0]  src_data [STAGES];
  logic [CNT_W-1:0]  src_cnt  [STAGES];
  logic [1:0]        src_op   [STAGES];
  logic              src_v    [STAGES];
  logic [WIDTH-1:0]  nxt_data [STAGES];

  // A stage may update when it is empty or the stage after it is moving on.
  always_comb begin
    adv[STAGES-1] = !v[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !v[k] || adv[k+1];
    end
  end

  genvar g;
  generate
    for (g = 0; g < STAGES; g++) begin : g_stage
      if (g == 0) begin : g_src_in
        assign src_data[g] = in_data;
        assign src_cnt[g]  = in_cnt;
        assign src_op[g]   = in_op;
        assign src_v[g]    = in_valid;
      end else begin : g_src_reg
        assign src_data[g] = data[g-1];
        assign src_cnt[g]  = cnt[g-1];
        assign src_op[g]   = op[g-1];
        assign src_v[g]    = v[g-1];
      end

      shift_stage #(.DIST(1 << g)) u_stage (
        .x  (src_data[g]),
        .en (src_cnt[g][g]),
        .op (src_op[g]),
        .y  (nxt_data[g])
      );

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v[g]    <= 1'b0;
          data[g] <= '0;
          cnt[g]  <= '0;
          op[g]   <= '0;
        end else if (adv[g]) begin
          v[g]    <= src_v[g];
          data[g] <= nxt_data[g];
          cnt[g]  <= src_cnt[g];
          op[g]   <= src_op[g];
        end
      end
    end
  endgenerate

  assign in_ready  = adv[0];
  assign out_valid = v[STAGES-1];
  assign out_data  = data[STAGES-1];
  assign busy      = |v;

endmodule

// File: tb/tb_shift_pipe.sv
// Scoreboarded bench for shift_pipe: directed cases, stalls, bubbles, reset, random traffic.
module tb_shift_pipe;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic [3:0]  in_cnt;
  logic [1:0]  in_op;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        busy;

  logic        ready_cmd;
  logic        rand_ready;
  logic        rnd_bit;

  logic [15:0] exp_q[$];
  int          errors = 0;
  int          checks = 0;

  assign out_ready = rand_ready ? rnd_bit : ready_cmd;

  shift_pipe dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_cnt    (in_cnt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  // clock / reset block
  always #5 clk = ~clk;

  initial begin
    rnd_bit = 1'b1;
    forever begin
      @(posedge clk);
      #1 rnd_bit = 1'($urandom_range(0, 1));
    end
  end

  // reference model: shift/rotate by n positions using plain arithmetic
  function automatic logic [15:0] ref_model(input logic [1:0] op, input logic [3:0] n,
                                            input logic [15:0] x);
    logic [31:0] dbl;
    logic [31:0] r;
    dbl = {x, x};
    case (op)
      2'b00:   begin r = dbl << n; return r[31:16]; end
      2'b01:   return x << n;
      2'b10:   begin r = dbl >> n; return r[15:0]; end
      default: return x >> n;
    endcase
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out: got %0h expected no output at %0t", out_data, $time);
      end else begin
        check("out_data", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
      end
    end
  end

  // driver: offer one op for up to budget cycles; push expected on acceptance
  task automatic issue(input logic [1:0] op, input logic [3:0] cnt, input logic [15:0] d,
                       input logic [15:0] exp, input int budget, output bit ok);
    in_valid = 1'b1;
    in_op    = op;
    in_cnt   = cnt;
    in_data  = d;
    ok       = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(exp);
        ok = 1'b1;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drain(input int budget);
    ready_cmd = 1'b1;
    for (int i = 0; i < budget && exp_q.size() > 0; i++) cycles(1);
    cycles(1);
    check("drain_left", exp_q.size(), 0);
  endtask

  logic [15:0] dir_exp [4];
  logic [15:0] held;
  bit          ok;
  int          accepted;
  int          lat;

  initial begin
    dir_exp[0] = 16'h874B;
    dir_exp[1] = 16'h8600;
    dir_exp[2] = 16'hE1D2;
    dir_exp[3] = 16'h0052;
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_cnt = '0; in_op = '0;
    ready_cmd = 1'b1; rand_ready = 1'b0;

    // reset state
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);
    cycles(3);
    @(negedge clk) rst_n = 1'b1;
    cycles(1);
    check("rel_in_ready", in_ready, 1);
    check("rel_out_valid", out_valid, 0);

    // each op on A5C3 by 9, with latency measurement
    for (int o = 0; o < 4; o++) begin
      issue(2'(o), 4'd9, 16'hA5C3, dir_exp[o], 4, ok);
      check("dir_accept", ok, 1);
      lat = 0;
      while (!out_valid && lat < 20) begin
        cycles(1);
        lat++;
      end
      check("latency", lat, 3);
      drain(20);
    end

    // back-to-back SRL stream on FFFF, counts 8..15
    for (int c = 8; c < 16; c++) begin
      issue(2'b11, 4'(c), 16'hFFFF, 16'hFFFF >> c, 1, ok);
      check("stream_accept", ok, 1);
      check("stream_busy", busy, 1);
    end
    drain(20);

    // stall: six offers against a blocked output
    ready_cmd = 1'b0;
    accepted = 0;
    for (int i = 0; i < 6; i++) begin
      issue(2'b00, 4'(i + 1), 16'h1234 + 16'(i), ref_model(2'b00, 4'(i + 1), 16'h1234 + 16'(i)), 1, ok);
      if (ok) accepted++;
    end
    check("stall_accepted", accepted, 4);
    check("stall_in_ready", in_ready, 0);
    held = out_data;
    cycles(3);
    check("stall_out_valid", out_valid, 1);
    check("stall_out_stable", out_data, held);
    ready_cmd = 1'b1;
    for (int i = 4; i < 6; i++) begin
      issue(2'b00, 4'(i + 1), 16'h1234 + 16'(i), ref_model(2'b00, 4'(i + 1), 16'h1234 + 16'(i)), 10, ok);
      check("stall_late_accept", ok, 1);
    end
    drain(30);

    // bubble collapse: second op moves up behind a stalled first op
    ready_cmd = 1'b0;
    issue(2'b01, 4'd3, 16'h00F1, 16'h0788, 1, ok);
    cycles(2);
    issue(2'b10, 4'd4, 16'h00F1, 16'h100F, 1, ok);
    check("bubble_accept", ok, 1);
    cycles(3);
    check("bubble_in_ready", in_ready, 1);
    check("bubble_out_data", out_data, 16'h0788);
    ready_cmd = 1'b1;
    cycles(1);
    check("bubble_second_next", out_valid, 1);
    drain(20);

    // reset with three entries in flight
    ready_cmd = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(2'b11, 4'd1, 16'h8000, 16'h4000, 1, ok);
    end
    cycles(2);
    check("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_busy", busy, 0);
    cycles(2);
    @(negedge clk) rst_n = 1'b1;
    ready_cmd = 1'b1;
    cycles(1);
    check("post_rst_in_ready", in_ready, 1);
    cycles(5);
    check("post_rst_out_valid", out_valid, 0);
    check("post_rst_busy", busy, 0);

    // count boundaries 0 and 15 for every op
    for (int o = 0; o < 4; o++) begin
      for (int b = 0; b < 2; b++) begin
        in_data = 16'($urandom);
        issue(2'(o), b ? 4'd15 : 4'd0, in_data, ref_model(2'(o), b ? 4'd15 : 4'd0, in_data), 10, ok);
      end
    end
    drain(20);

    // random traffic with random output back-pressure
    rand_ready = 1'b1;
    for (int i = 0; i < 300; i++) begin
      logic [1:0]  r_op;
      logic [3:0]  r_cnt;
      logic [15:0] r_data;
      r_op   = 2'($urandom_range(0, 3));
      r_cnt  = 4'($urandom_range(0, 15));
      r_data = 16'($urandom);
      issue(r_op, r_cnt, r_data, ref_model(r_op, r_cnt, r_data), 50, ok);
      if (!ok) check("rand_accept_timeout", ok, 1);
      if ($urandom_range(0, 3) == 0) cycles($urandom_range(1, 3));
    end
    rand_ready = 1'b0;
    drain(100);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
